// File: rtl/div_operand_queue_if.sv
// Handshake bundle for the divider issue queue: operand pairs in, results out.
// The slave modport is the queue's view; master is the upstream/downstream view.
interface div_operand_queue_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_lop;
    logic [WIDTH-1:0] in_rop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_mod;
    logic             out_dbz;

    modport master (
        output in_valid, in_lop, in_rop, out_ready,
        input  in_ready, out_valid, out_quot, out_mod, out_dbz
    );

    modport slave (
        input  in_valid, in_lop, in_rop, out_ready,
        output in_ready, out_valid, out_quot, out_mod, out_dbz
    );
endinterface

// File: rtl/div_operand_queue.sv
// Buffered issue stage in front of the 8-bit combinational divider.
// Operand pairs are queued in a small FIFO; the head pair drives the divider
// and its result is registered into a single output slot. A zero divisor is
// resolved here (quot = all ones, mod = dividend) so the divider's undefined
// output never reaches downstream logic. WIDTH must be 8 to match the divider.
module div_operand_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    div_operand_queue_if.slave     bus,
    output logic [WIDTH-1:0]       div_lop,
    output logic [WIDTH-1:0]       div_rop,
    input  logic [WIDTH-1:0]       div_quot,
    input  logic [WIDTH-1:0]       div_mod,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] lop_mem [DEPTH];
    logic [WIDTH-1:0] rop_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_lop;
    logic [WIDTH-1:0] head_rop;

    // in_ready ignores a same-cycle pop so it has no combinational path from out_ready.
    assign empty        = (count == '0);
    assign bus.in_ready = (count < DEPTH_C) && !reset;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = !empty && (!bus.out_valid || bus.out_ready);

    assign head_lop = lop_mem[rd_ptr];
    assign head_rop = rop_mem[rd_ptr];
    assign div_lop  = empty ? '0 : head_lop;
    assign div_rop  = empty ? '0 : head_rop;

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            lop_mem[wr_ptr] <= bus.in_lop;
            rop_mem[wr_ptr] <= bus.in_rop;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output slot: capture the head result on pop, release on downstream accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_quot  <= '0;
            bus.out_mod   <= '0;
            bus.out_dbz   <= 1'b0;
        end else if (pop) begin
            bus.out_valid <= 1'b1;
            if (head_rop != '0) begin
                bus.out_quot <= div_quot;
                bus.out_mod  <= div_mod;
                bus.out_dbz  <= 1'b0;
            end else begin
                bus.out_quot <= '1;
                bus.out_mod  <= head_lop;
                bus.out_dbz  <= 1'b1;
            end
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div_operand_queue.sv
// Directed bench for div_operand_queue with a behavioural divider and a
// result scoreboard filled at accepted pushes and drained at accepted results.
module tb_div_operand_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] m;
        logic       d;
    } res_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] div_lop, div_rop, div_quot, div_mod;
    logic [$clog2(DEPTH):0] count;

    div_operand_queue_if #(.WIDTH(8)) bus ();

    div_operand_queue #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .div_lop  (div_lop),
        .div_rop  (div_rop),
        .div_quot (div_quot),
        .div_mod  (div_mod),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Divider stand-in; a zero divisor yields junk the queue must ignore.
    always_comb begin
        div_quot = 8'hA5;
        div_mod  = 8'h5A;
        if (div_rop != 8'd0) begin
            div_quot = div_lop / div_rop;
            div_mod  = div_lop % div_rop;
        end
    end

    res_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_accepted = 0;
    int   n_results  = 0;

    function automatic res_t model(input logic [7:0] l, input logic [7:0] r);
        res_t e;
        if (r == 8'd0) begin
            e.q = 8'hFF; e.m = l; e.d = 1'b1;
        end else begin
            e.q = l / r; e.m = l % r; e.d = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: scoreboard work at the falling edge, then return 1 after the rising edge.
    task automatic tick();
        res_t e;
        @(negedge clk);
        if (!reset && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", sb.size(), 1);
            end else begin
                e = sb[0];
                chk("out_quot", bus.out_quot, e.q);
                chk("out_mod",  bus.out_mod,  e.m);
                chk("out_dbz",  bus.out_dbz,  e.d);
                if (bus.out_ready) begin
                    e = sb.pop_front();
                    n_results++;
                end
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.in_lop, bus.in_rop));
            n_accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] l, input logic [7:0] r);
        bus.in_valid = 1'b1;
        bus.in_lop   = l;
        bus.in_rop   = r;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        tick();
        chk(tag, sb.size(), 0);
    endtask

    int base;

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_lop = '0; bus.in_rop = '0;
        bus.out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_quot", bus.out_quot, 0);
        chk("rst_out_mod", bus.out_mod, 0);
        chk("rst_out_dbz", bus.out_dbz, 0);
        chk("rst_div_lop", div_lop, 0);
        chk("rst_div_rop", div_rop, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Basic results and two-edge latency.
        bus.out_ready = 1'b1;
        drive(8'd5, 8'd3);   tick();
        chk("lat_out_valid_n", bus.out_valid, 0);
        chk("lat_div_lop", div_lop, 5);
        drive(8'd45, 8'd13); tick();
        chk("lat_out_valid_n1", bus.out_valid, 1);
        drive(8'd20, 8'd5);  tick();
        bus.in_valid = 1'b0;
        drain("basic_drain");
        chk("basic_results", n_results, 3);

        // Divide by zero, then a normal divide.
        drive(8'd7, 8'd0); tick();
        drive(8'd9, 8'd4); tick();
        bus.in_valid = 1'b0;
        drain("dbz_drain");
        chk("empty_div_rop", div_rop, 0);

        // Backpressure until full.
        bus.out_ready = 1'b0;
        base = n_accepted;
        for (int i = 0; i < 5; i++) begin
            drive(8'(10 + i), 8'd1);
            tick();
        end
        chk("bp_accepted", n_accepted - base, 5);
        chk("bp_count_full", count, DEPTH);
        chk("bp_in_ready", bus.in_ready, 0);
        drive(8'd15, 8'd1);
        tick(); tick();
        chk("bp_hold_count", count, DEPTH);
        chk("bp_hold_accepted", n_accepted - base, 5);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.in_ready) begin
                tick();
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_sixth_accepted", n_accepted - base, 6);
        drain("bp_drain");

        // Sustained simultaneous push/pop at count=2 across pointer wrap.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8'(30 + i), 8'(i + 2));
            tick();
        end
        chk("sim_count_start", count, 2);
        chk("sim_out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 7)));
            tick();
            chk("sim_count", count, 2);
        end
        bus.in_valid = 1'b0;
        drain("sim_drain");

        // Reset in the middle of operation.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'(50 + i), 8'd7);
            tick();
        end
        chk("mid_count", count, 3);
        chk("mid_out_valid", bus.out_valid, 1);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_count", count, 0);
        chk("mrst_out_quot", bus.out_quot, 0);
        chk("mrst_out_mod", bus.out_mod, 0);
        chk("mrst_in_ready_hi", bus.in_ready, 0);
        sb.delete();
        reset = 1'b0;
        #1;
        chk("mrst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        base = n_results;
        drive(8'd8, 8'd3); tick();
        bus.in_valid = 1'b0;
        drain("mrst_drain");
        chk("mrst_results", n_results - base, 1);
        chk("final_count", count, 0);
        chk("final_out_valid", bus.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
